seq_pattern_gen: RTL and testbench

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

---
 rtl/seq_pkg.sv | 7 +
 rtl/seq_shift_reg.sv | 35 +++
 rtl/seq_pattern_gen.sv | 76 +++++++
 tb/tb_seq_pattern_gen.sv | 104 ++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: state encoding and default frame settings shared by the pattern generator and the detector
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  localparam int MAX_LEN = 8;
  localparam logic [7:0] DEFAULT_PATTERN = 8'b0001_0101;
  localparam int DEFAULT_LEN = 5;
endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: parallel-load MSB-first shift register with bit-index down-counter
module seq_shift_reg #(
  parameter int W = 8,
  parameter int LW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  din,
  input  logic [LW-1:0] dlen,
  output logic          bit_out,
  output logic          last
);
  logic [W-1:0] sreg;
  logic [LW-1:0] idx;
  // frame is left-aligned so the head bit is always sreg[W-1] and zeros follow the last bit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sreg <= '0;
      idx <= '0;
    end else if (clr) begin
      sreg <= '0;
      idx <= '0;
    end else if (load) begin
      sreg <= din << (LW'(W) - dlen);
      idx <= dlen - LW'(1);
    end else if (shift) begin
      sreg <= sreg << 1;
      idx <= idx - LW'(1);
    end
  assign bit_out = sreg[W-1];
  assign last = idx == '0;
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial frame generator with repeat count, optional inter-frame gap and abort
module seq_pattern_gen #(
  parameter int MAX_LEN = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0001_0101),
  parameter int DEFAULT_LEN = 5,
  localparam int LW = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               use_default,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LW-1:0]      len,
  input  logic [3:0]         repeat_cnt,
  input  logic               gap_en,
  input  logic               abort,
  output logic               in_out,
  output logic               valid,
  output logic               busy,
  output logic               done
);
  import seq_pkg::*;
  state_t state, nxt;
  logic [MAX_LEN-1:0] pat_q, ld_pat;
  logic [LW-1:0] len_q, eff_len, ld_len;
  logic [3:0] frames;
  logic gap_q, accept, next_frame, load, shift, clr, last;
  assign eff_len = use_default ? LW'(DEFAULT_LEN) : len;
  assign accept = state == IDLE && start && !abort && eff_len != '0 && eff_len <= LW'(MAX_LEN);
  assign next_frame = state == SHIFT && last && frames != '0 && !abort;
  assign ld_pat = accept ? (use_default ? DEFAULT_PATTERN : pattern) : pat_q;
  assign ld_len = accept ? eff_len : len_q;
  always_comb begin
    clr = abort && state != IDLE;
    load = !clr && (accept || state == GAP || (next_frame && !gap_q));
    shift = !clr && state == SHIFT && !load;
    nxt = clr ? IDLE :
          state == IDLE ? (accept ? SHIFT : IDLE) :
          state == SHIFT ? (!last ? SHIFT : frames == '0 ? DONE : gap_q ? GAP : SHIFT) :
          state == GAP ? SHIFT : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      frames <= '0;
      gap_q <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      valid <= nxt == SHIFT;
      busy <= nxt == SHIFT || nxt == GAP;
      done <= nxt == DONE;
      if (accept) begin
        pat_q <= ld_pat;
        len_q <= eff_len;
        frames <= repeat_cnt;
        gap_q <= gap_en;
      end else if (next_frame)
        frames <= frames - 4'd1;
    end
  seq_shift_reg #(.W(MAX_LEN), .LW(LW)) u_sr (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .load(load),
    .shift(shift),
    .din(ld_pat),
    .dlen(ld_len),
    .bit_out(in_out),
    .last(last)
  );
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: randomized frame transfers checked against a per-cycle expected-output queue
module tb_seq_pattern_gen;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, use_default = 1'b0, gap_en = 1'b0, abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0, repeat_cnt = '0;
  logic in_out, valid, busy, done;
  int n_chk = 0, n_pass = 0;

  seq_pattern_gen dut (
    .clk(clk), .reset(reset), .start(start), .use_default(use_default), .pattern(pattern),
    .len(len), .repeat_cnt(repeat_cnt), .gap_en(gap_en), .abort(abort),
    .in_out(in_out), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ab: 0 = no abort, >0 = abort during that output cycle, <0 = random abort cycle
  task automatic run(input bit ud, input logic [7:0] p, input logic [3:0] l, input logic [3:0] rc,
                     input bit g, input int ab, input bit hold, input string name);
    logic [3:0] q[$];
    logic [7:0] ep;
    int el, a;
    el = ud ? 5 : int'(l);
    ep = ud ? 8'b0001_0101 : p;
    if (el >= 1 && el <= 8) begin
      for (int f = 0; f <= int'(rc); f++) begin
        for (int b = el - 1; b >= 0; b--) q.push_back({ep[b], 3'b110});
        if (g && f < int'(rc)) q.push_back(4'b0010);
      end
      q.push_back(4'b0001);
    end
    a = ab;
    if (a < 0) a = (q.size() >= 2) ? int'($urandom_range(1, q.size() - 1)) : 0;
    if (a > 0 && a < q.size()) while (q.size() > a) void'(q.pop_back());
    else a = 0;
    q.push_back(4'b0000);
    use_default = ud; pattern = p; len = l; repeat_cnt = rc; gap_en = g; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (i == q.size() - 1) start = 1'b0;
      if (el >= 1 && el <= 8) begin
        pattern = 8'($urandom); len = 4'($urandom); repeat_cnt = 4'($urandom);
        gap_en = 1'($urandom); use_default = 1'($urandom);
      end
      abort = (i + 1 == a);
      @(negedge clk);
      check($sformatf("%s c%0d", name, i + 1), {in_out, valid, busy, done}, q[i]);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #1;
    check("rst in_out", in_out, 0);
    check("rst valid", valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    run(1, 8'h00, 4'd0, 4'd0, 0, 0, 0, "dflt");
    run(1, 8'h00, 4'd0, 4'd2, 0, 0, 0, "dflt_x3");
    run(0, 8'b1011_0110, 4'd8, 4'd1, 1, 0, 0, "gap");
    run(1, 8'h00, 4'd0, 4'd2, 0, 3, 0, "abort");
    run(0, 8'b1100_1010, 4'd6, 4'd0, 0, 0, 0, "post_abort");
    run(0, 8'hFF, 4'd0, 4'd0, 0, 0, 0, "len0");
    run(0, 8'hFF, 4'd9, 4'd0, 0, 0, 0, "len9");
    run(0, 8'h01, 4'd1, 4'd15, 1, 0, 0, "rep15");
    run(0, 8'hA5, 4'd8, 4'd2, 0, 0, 1, "hold");
    use_default = 1'b0; pattern = 8'hFF; len = 4'd8; repeat_cnt = 4'd0; gap_en = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst in_out", in_out, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst in_out", in_out, 0);
    check("midrst valid", valid, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst busy", busy, 0);
    check("post_rst valid", valid, 0);
    for (int t = 0; t < 30; t++)
      run(1'($urandom), 8'($urandom), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 4)),
          1'($urandom), ($urandom_range(0, 3) == 0) ? -1 : 0, 1'($urandom), $sformatf("rnd%0d", t));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
